// File: rtl/lsu_scoreboard_ctrl_pkg.sv
// Shared encodings for the long-latency unit scoreboard: register-file select,
// source bit positions in float_read/src_used, and the default in-flight limit.
package lsu_scoreboard_ctrl_pkg;

    localparam logic RF_INT = 1'b0;
    localparam logic RF_FP  = 1'b1;

    localparam int SRC_RS1 = 2;
    localparam int SRC_RS2 = 1;
    localparam int SRC_RS3 = 0;

    localparam int SB_MAX_OUT = 2;

endpackage

// File: rtl/lsu_scoreboard_ctrl_sb_bitmap.sv
// 32-entry pending-register bitmap with one set port, one clear port and three read ports.
// Updates land at the clock edge; reads reflect registered state only.
module sb_bitmap #(
    parameter bit ZERO_X0 = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_en_i,
    input  logic [4:0]  set_idx_i,
    input  logic        clr_en_i,
    input  logic [4:0]  clr_idx_i,
    input  logic [4:0]  rd0_idx_i,
    input  logic [4:0]  rd1_idx_i,
    input  logic [4:0]  rd2_idx_i,
    output logic        rd0_o,
    output logic        rd1_o,
    output logic        rd2_o,
    output logic [31:0] pend_o
);

    logic [31:0] pend_q;
    logic [31:0] pend_d;

    always_comb begin
        pend_d = pend_q;
        if (clr_en_i) pend_d[clr_idx_i] = 1'b0;
        if (set_en_i) pend_d[set_idx_i] = 1'b1;
        // x0 is never a real destination in the integer file
        if (ZERO_X0) pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) pend_q <= '0;
        else     pend_q <= pend_d;
    end

    assign rd0_o  = pend_q[rd0_idx_i];
    assign rd1_o  = pend_q[rd1_idx_i];
    assign rd2_o  = pend_q[rd2_idx_i];
    assign pend_o = pend_q;

endmodule

// File: rtl/lsu_scoreboard_ctrl.sv
// Issue-stage scoreboard for the shared long-latency unit: stalls ID/PC on RAW/WAW/full,
// pulses unit_start on issue, retires on writeback. Stall is combinational; wb releases next cycle.
module lsu_scoreboard_ctrl
    import lsu_scoreboard_ctrl_pkg::*;
#(
    parameter int MAX_OUT = SB_MAX_OUT,
    parameter int CNT_W   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic       id_long,
    input  logic       id_wr,
    input  logic       id_fw,
    input  logic [4:0] id_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] id_rs3,
    input  logic [2:0] float_read,
    input  logic [2:0] src_used,
    input  logic       flush,
    input  logic       wb_valid,
    input  logic       wb_fw,
    input  logic [4:0] wb_rd,
    output logic       id_stall,
    output logic       pc_stall,
    output logic       unit_start,
    output logic       busy,
    output logic       full,
    output logic       err
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [31:0]      pend_i, pend_f;
    logic [2:0]       hit_i, hit_f;
    logic             src_haz, waw_haz, res_haz, issue, wb_hit, wb_x0;

    sb_bitmap #(.ZERO_X0(1'b1)) u_bm_int (
        .clk       (clk),
        .rst       (rst),
        .set_en_i  (issue && id_wr && (id_fw == RF_INT)),
        .set_idx_i (id_rd),
        .clr_en_i  (wb_valid && (wb_fw == RF_INT)),
        .clr_idx_i (wb_rd),
        .rd0_idx_i (id_rs1),
        .rd1_idx_i (id_rs2),
        .rd2_idx_i (id_rs3),
        .rd0_o     (hit_i[SRC_RS1]),
        .rd1_o     (hit_i[SRC_RS2]),
        .rd2_o     (hit_i[SRC_RS3]),
        .pend_o    (pend_i)
    );

    sb_bitmap #(.ZERO_X0(1'b0)) u_bm_fp (
        .clk       (clk),
        .rst       (rst),
        .set_en_i  (issue && id_wr && (id_fw == RF_FP)),
        .set_idx_i (id_rd),
        .clr_en_i  (wb_valid && (wb_fw == RF_FP)),
        .clr_idx_i (wb_rd),
        .rd0_idx_i (id_rs1),
        .rd1_idx_i (id_rs2),
        .rd2_idx_i (id_rs3),
        .rd0_o     (hit_f[SRC_RS1]),
        .rd1_o     (hit_f[SRC_RS2]),
        .rd2_o     (hit_f[SRC_RS3]),
        .pend_o    (pend_f)
    );

    assign src_haz = |(src_used & ((float_read & hit_f) | (~float_read & hit_i)));
    assign waw_haz = id_wr && ((id_fw == RF_FP) ? pend_f[id_rd] : pend_i[id_rd]);
    assign full    = (cnt_q == CNT_W'(MAX_OUT));
    assign res_haz = id_long && full;

    assign id_stall   = id_valid && !flush && (src_haz || waw_haz || res_haz);
    assign pc_stall   = id_stall;
    assign issue      = id_valid && id_long && !id_stall && !flush;
    assign unit_start = issue;

    assign wb_x0  = (wb_fw == RF_INT) && (wb_rd == 5'd0);
    assign wb_hit = (wb_fw == RF_FP) ? pend_f[wb_rd] : pend_i[wb_rd];

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (issue && !wb_valid) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (wb_valid && !issue && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        // A writeback nobody asked for means the unit and the scoreboard disagree
        if (wb_valid && ((!wb_hit && !wb_x0) || (cnt_q == '0))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign busy = (cnt_q != '0);
    assign err  = err_q;

endmodule

// File: tb/tb_lsu_scoreboard_ctrl.sv
// Directed bench for lsu_scoreboard_ctrl with MAX_OUT=2; expected values are hand-derived.
module tb_lsu_scoreboard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_long, id_wr, id_fw, flush;
    logic [4:0] id_rd, id_rs1, id_rs2, id_rs3;
    logic [2:0] float_read, src_used;
    logic       wb_valid, wb_fw;
    logic [4:0] wb_rd;
    logic       id_stall, pc_stall, unit_start, busy, full, err;

    int n_asrt  = 0;
    int n_fail  = 0;
    int n_start = 0;
    int s0;

    always #5 clk = ~clk;

    lsu_scoreboard_ctrl #(.MAX_OUT(2), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_long    (id_long),
        .id_wr      (id_wr),
        .id_fw      (id_fw),
        .id_rd      (id_rd),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rs3     (id_rs3),
        .float_read (float_read),
        .src_used   (src_used),
        .flush      (flush),
        .wb_valid   (wb_valid),
        .wb_fw      (wb_fw),
        .wb_rd      (wb_rd),
        .id_stall   (id_stall),
        .pc_stall   (pc_stall),
        .unit_start (unit_start),
        .busy       (busy),
        .full       (full),
        .err        (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_asrt++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic lg, input logic wr, input logic fw,
                       input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] r3, input logic [2:0] fr, input logic [2:0] su,
                       input logic fl);
        id_valid = v; id_long = lg; id_wr = wr; id_fw = fw; id_rd = rd;
        id_rs1 = r1; id_rs2 = r2; id_rs3 = r3; float_read = fr; src_used = su; flush = fl;
        #1;
    endtask

    task automatic idle;
        drv(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000, 3'b000, 0);
    endtask

    task automatic wb(input logic v, input logic fw, input logic [4:0] rd);
        wb_valid = v; wb_fw = fw; wb_rd = rd;
        #1;
    endtask

    // Long op writing the same reg that is retiring in the same cycle must never be seen
    always @(negedge clk) begin
        if (unit_start) n_start++;
        if (!rst && unit_start && id_wr && wb_valid && (id_fw == wb_fw) && (id_rd == wb_rd))
            check_eq("issue_wb_same_reg", 32'd1, 32'd0);
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle();
        wb(0, 0, 5'd0);
        repeat (2) tick();
        check_eq("rst_id_stall", id_stall, 0);
        check_eq("rst_pc_stall", pc_stall, 0);
        check_eq("rst_start", unit_start, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_full", full, 0);
        check_eq("rst_err", err, 0);
        rst = 1'b0;

        // RAW on integer x5 held until the cycle after its writeback
        tick();
        s0 = n_start;
        drv(1, 1, 1, 0, 5'd5, 5'd1, 5'd2, 5'd0, 3'b000, 3'b110, 0);
        check_eq("div_start", unit_start, 1);
        check_eq("div_nostall", id_stall, 0);
        tick();
        drv(1, 0, 1, 0, 5'd6, 5'd5, 5'd0, 5'd0, 3'b000, 3'b100, 0);
        check_eq("raw_x5_stall", id_stall, 1);
        check_eq("raw_x5_pcstall", pc_stall, 1);
        check_eq("raw_x5_nostart", unit_start, 0);
        check_eq("raw_x5_busy", busy, 1);
        check_eq("raw_x5_notfull", full, 0);
        tick();
        check_eq("raw_x5_stall_c2", id_stall, 1);
        wb(1, 0, 5'd5);
        check_eq("raw_x5_stall_wbcyc", id_stall, 1);
        tick();
        wb(0, 0, 5'd0);
        check_eq("raw_x5_release", id_stall, 0);
        check_eq("raw_x5_release_pc", pc_stall, 0);
        check_eq("x5_retired_busy", busy, 0);
        check_eq("x5_err", err, 0);
        check_eq("x5_one_start", n_start - s0, 1);
        idle();

        // float pending f3 does not block integer x3
        tick();
        drv(1, 1, 1, 1, 5'd3, 5'd1, 5'd2, 5'd0, 3'b110, 3'b110, 0);
        check_eq("fdiv_start", unit_start, 1);
        tick();
        drv(1, 0, 1, 0, 5'd8, 5'd3, 5'd0, 5'd0, 3'b000, 3'b100, 0);
        check_eq("int_x3_nostall", id_stall, 0);
        drv(1, 0, 1, 1, 5'd4, 5'd3, 5'd4, 5'd0, 3'b110, 3'b110, 0);
        check_eq("fadd_f3_stall", id_stall, 1);
        drv(1, 0, 1, 0, 5'd4, 5'd9, 5'd3, 5'd0, 3'b000, 3'b010, 0);
        check_eq("int_rs2_x3_nostall", id_stall, 0);
        drv(1, 0, 1, 1, 5'd3, 5'd0, 5'd0, 5'd0, 3'b000, 3'b000, 0);
        check_eq("waw_f3_stall", id_stall, 1);
        drv(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd3, 3'b001, 3'b001, 0);
        check_eq("rs3_f3_stall", id_stall, 1);
        idle();
        wb(1, 1, 5'd3);
        tick();
        wb(0, 0, 5'd0);
        check_eq("f3_retired_busy", busy, 0);
        check_eq("f3_err", err, 0);

        // x0 destination counts but never hazards nor flags err
        drv(1, 1, 1, 0, 5'd0, 5'd1, 5'd0, 5'd0, 3'b000, 3'b100, 0);
        check_eq("x0_start", unit_start, 1);
        tick();
        idle();
        check_eq("x0_busy", busy, 1);
        drv(1, 0, 1, 0, 5'd1, 5'd0, 5'd0, 5'd0, 3'b000, 3'b110, 0);
        check_eq("x0_read_nostall", id_stall, 0);
        idle();
        wb(1, 0, 5'd0);
        tick();
        wb(0, 0, 5'd0);
        check_eq("x0_wb_err", err, 0);
        check_eq("x0_wb_busy", busy, 0);

        // resource hazard at MAX_OUT=2
        drv(1, 1, 1, 0, 5'd1, 5'd0, 5'd0, 5'd0, 3'b000, 3'b000, 0);
        tick();
        drv(1, 1, 1, 0, 5'd2, 5'd0, 5'd0, 5'd0, 3'b000, 3'b000, 0);
        check_eq("second_start", unit_start, 1);
        tick();
        idle();
        check_eq("full_two", full, 1);
        check_eq("busy_two", busy, 1);
        drv(1, 1, 1, 0, 5'd4, 5'd0, 5'd0, 5'd0, 3'b000, 3'b000, 0);
        check_eq("third_stall", id_stall, 1);
        check_eq("third_nostart", unit_start, 0);
        wb(1, 0, 5'd1);
        check_eq("third_stall_wbcyc", id_stall, 1);
        tick();
        wb(0, 0, 5'd0);
        check_eq("after_wb_notfull", full, 0);
        check_eq("third_release", id_stall, 0);
        check_eq("third_start", unit_start, 1);
        tick();
        idle();
        check_eq("full_again", full, 1);
        wb(1, 0, 5'd2);
        tick();
        wb(1, 0, 5'd4);
        tick();
        wb(0, 0, 5'd0);
        check_eq("drain_busy", busy, 0);
        check_eq("drain_err", err, 0);

        // issue x7 while x9 retires: count stays at one
        drv(1, 1, 1, 0, 5'd9, 5'd0, 5'd0, 5'd0, 3'b000, 3'b000, 0);
        tick();
        drv(1, 1, 1, 0, 5'd7, 5'd0, 5'd0, 5'd0, 3'b000, 3'b000, 0);
        wb(1, 0, 5'd9);
        check_eq("x7_start", unit_start, 1);
        tick();
        idle();
        wb(0, 0, 5'd0);
        check_eq("simul_busy", busy, 1);
        check_eq("simul_notfull", full, 0);
        drv(1, 0, 1, 0, 5'd20, 5'd7, 5'd0, 5'd0, 3'b000, 3'b100, 0);
        check_eq("x7_pending", id_stall, 1);
        drv(1, 0, 1, 0, 5'd20, 5'd9, 5'd0, 5'd0, 3'b000, 3'b100, 0);
        check_eq("x9_cleared", id_stall, 0);
        idle();
        wb(1, 0, 5'd7);
        tick();
        wb(0, 0, 5'd0);
        check_eq("x7_retired_busy", busy, 0);

        // flush blocks issue and stall, earlier op still retires
        drv(1, 1, 1, 0, 5'd10, 5'd0, 5'd0, 5'd0, 3'b000, 3'b000, 0);
        tick();
        drv(1, 1, 1, 0, 5'd11, 5'd10, 5'd0, 5'd0, 3'b000, 3'b100, 1);
        check_eq("flush_nostart", unit_start, 0);
        check_eq("flush_nostall", id_stall, 0);
        tick();
        idle();
        check_eq("flush_busy", busy, 1);
        check_eq("flush_notfull", full, 0);
        drv(1, 0, 1, 0, 5'd20, 5'd11, 5'd0, 5'd0, 3'b000, 3'b100, 0);
        check_eq("x11_not_set", id_stall, 0);
        drv(1, 0, 1, 0, 5'd20, 5'd10, 5'd0, 5'd0, 3'b000, 3'b100, 0);
        check_eq("x10_still_pending", id_stall, 1);
        idle();
        wb(1, 0, 5'd10);
        tick();
        wb(0, 0, 5'd0);
        check_eq("x10_retired_busy", busy, 0);
        check_eq("x10_err", err, 0);

        // spurious writeback is sticky until reset
        wb(1, 0, 5'd12);
        tick();
        wb(0, 0, 5'd0);
        check_eq("spurious_err", err, 1);
        check_eq("spurious_busy", busy, 0);
        tick();
        tick();
        check_eq("err_sticky", err, 1);
        drv(1, 1, 1, 0, 5'd13, 5'd0, 5'd0, 5'd0, 3'b000, 3'b000, 0);
        tick();
        drv(1, 1, 1, 0, 5'd14, 5'd0, 5'd0, 5'd0, 3'b000, 3'b000, 0);
        tick();
        idle();
        check_eq("preflush_full", full, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_full", full, 0);
        check_eq("midrst_err", err, 0);
        drv(1, 0, 1, 0, 5'd20, 5'd13, 5'd14, 5'd0, 3'b000, 3'b110, 0);
        check_eq("midrst_pend_clear", id_stall, 0);
        drv(1, 1, 1, 0, 5'd13, 5'd0, 5'd0, 5'd0, 3'b000, 3'b000, 0);
        check_eq("midrst_can_issue", unit_start, 1);
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_scoreboard_ctrl.md
Name: lsu_scoreboard_ctrl

Overview:
- Issue-stage scoreboard and sequencer for the shared long-latency execution unit (integer div/rem, FP div/sqrt).
- Tracks destination registers of in-flight long ops across the integer and float register files.
- Stalls ID/PC on RAW/WAW hazards against pending registers, or when the unit has no free slot.
- Issues start pulses to the unit and retires entries on unit writeback.
- Sits beside the load-use hazard detector; the two stall sources are ORed upstream.

Parameters:
- MAX_OUT, 2, maximum long ops in flight in the shared unit (1..7).
- CNT_W, 3, width of the outstanding counter; must satisfy 2^CNT_W > MAX_OUT.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  valid instruction in ID
- id_long  in  1  ID instruction executes in the long-latency unit
- id_wr  in  1  ID instruction writes a destination register
- id_fw  in  1  destination is the float file (0 = integer)
- id_rd  in  5  destination register
- id_rs1, id_rs2, id_rs3  in  5 each  source registers
- float_read  in  3  [2]=rs1, [1]=rs2, [0]=rs3 read the float file
- src_used  in  3  [2]=rs1, [1]=rs2, [0]=rs3 actually read
- flush  in  1  kill the ID instruction this cycle
- wb_valid  in  1  long unit writing back this cycle
- wb_fw  in  1  writeback target file
- wb_rd  in  5  writeback register
- id_stall  out  1  hold the ID register
- pc_stall  out  1  hold the PC (equal to id_stall)
- unit_start  out  1  single-cycle start pulse to the long unit
- busy  out  1  outstanding count != 0
- full  out  1  outstanding count == MAX_OUT
- err  out  1  sticky: writeback with no matching pending bit

Behaviour:
- State: pend_i[31:0], pend_f[31:0], cnt[CNT_W-1:0], err.
  - All are cleared on rst, which has priority over every other event.
  - pend_i[0] is hard-wired 0.
- Source hazard: for each source k with src_used[k], test pend_f or pend_i (selected by float_read[k]) at rs_k.
  - Integer x0 never hazards.
- WAW hazard: id_wr && pending[id_fw][id_rd].
- Resource hazard: id_long && full.
- id_stall = id_valid && !flush && (source hazard || WAW hazard || resource hazard).
  - Combinational from registered state; no writeback bypass.
  - A register freed by wb this cycle still stalls ID this cycle and releases next cycle.
- Issue (= unit_start) = id_valid && id_long && !id_stall && !flush.
  - unit_start is combinational, one pulse per issued op.
  - On issue with id_wr, set the pending bit for (id_fw, id_rd) at the clock edge.
  - On issue, increment cnt. id_wr=0, or integer rd=0, sets no bit but still counts.
- Writeback: on wb_valid, clear the pending bit for (wb_fw, wb_rd) and decrement cnt.
  - If that bit was 0 (excluding integer x0 writes) or cnt==0, set err. err is cleared only by rst.
  - cnt never underflows: it saturates at 0.
- Simultaneous issue and wb: cnt is unchanged; the bit set and the bit clear apply independently.
  - Same reg in both cannot occur, because WAW stalls. The bench asserts it never happens.
- flush blocks issue and stall that cycle. It never clears pending bits: in-flight ops always retire.
- busy = cnt!=0; full = cnt==MAX_OUT. Both are derived from the registered cnt; reset value 0.
- Reset value of every output is 0 (given id_valid=0).
- Latency: hazard to stall is 0 cycles. wb to stall release is 1 cycle.

Decomposition:
- Shared package holds:
  - the register-file select encoding (RF_INT=0, RF_FP=1);
  - the source-index constants for float_read and src_used bit positions;
  - MAX_OUT.
- One natural sub-module: sb_bitmap (32-bit pending vector with set port, clear port and 3 read ports), instantiated once per file; the integer instance forces bit 0 low.

Test Plan:
- Reset, then an int div issues to x5 at cycle 1; next cycle an add reads x5 -> id_stall=pc_stall=1 until the cycle after wb(x5), then 0. unit_start pulses exactly once.
- fdiv to f3 is in flight. An integer instruction reads x3 -> no stall. fadd with float_read[2]=1 on rs1=3 -> stall.
- MAX_OUT=2: two long ops to x1 and x2 -> full=1. A third long op to x4 -> stalls. wb(x1) -> full=0 next cycle and the third op issues.
- Issue to x7 while wb(x9) in the same cycle with cnt=1 -> cnt stays 1, pend x7=1, x9=0.
- Long op with flush=1 -> unit_start=0, no pending bit set, cnt unchanged. A pending op issued earlier still retires normally.
- wb to x12 with nothing pending -> err=1 and stays 1. rst mid-flight (cnt=2) -> all pending, cnt, err and busy read 0 the next cycle.
